// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - opcode, MemWr/MemtoReg encodings and FSM state for the MEM stage
package mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [2:0] MEMWR_NONE = 3'd0;
    localparam logic [2:0] MEMWR_SW   = 3'd1;
    localparam logic [2:0] MEMWR_SH   = 3'd2;
    localparam logic [2:0] MEMWR_SB   = 3'd3;

    localparam logic [1:0] M2R_ALU  = 2'd0;
    localparam logic [1:0] M2R_LOAD = 2'd1;
    localparam logic [1:0] M2R_LINK = 2'd2;
    localparam logic [1:0] M2R_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } mem_state_t;

    function automatic logic is_load_op(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - extracts and sign/zero-extends the loaded byte, half or word
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [5:0]  opcode,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (opcode)
            OP_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  value = {24'd0, byte_sel};
            OP_LH:   value = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  value = {16'd0, half_sel};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory req/ack access, stall, MEM/WB register
// Optional misaligned-access abort: define MEM_ALIGN_CHECK_EN.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Mem_ins,
    input  logic [29:0] Mem_pc,
    input  logic        Mem_overflow,
    input  logic [31:0] Mem_aluout,
    input  logic [31:0] Mem_din,
    input  logic [4:0]  Mem_Rw,
    input  logic        Mem_RegWr,
    input  logic [1:0]  Mem_MemtoReg,
    input  logic [2:0]  Mem_MemWr,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [29:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        mem_stall,
    output logic [31:0] Wb_data,
    output logic [4:0]  Wb_Rw,
    output logic        Wb_RegWr,
    output logic        bus_err
);

    localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    mem_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [5:0]    opcode;
    logic [1:0]    a_lo;
    logic          is_store, is_load, mem_op, misaligned, issue, align_abort;
    logic [3:0]    be;
    logic [31:0]   wdata, load_val, nonmem_data;
    logic          unused_ins;

    assign opcode     = Mem_ins[31:26];
    assign a_lo       = Mem_aluout[1:0];
    assign unused_ins = ^Mem_ins[25:0];

    always_comb begin
        is_store = Mem_MemWr inside {MEMWR_SW, MEMWR_SH, MEMWR_SB};
        is_load  = (Mem_MemtoReg == M2R_LOAD) && is_load_op(opcode) && !is_store;
        mem_op   = (is_load || is_store) && !Mem_overflow;
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = (((is_load && opcode == OP_LW) || Mem_MemWr == MEMWR_SW) && a_lo != 2'b00)
                  || (((is_load && (opcode == OP_LH || opcode == OP_LHU)) || Mem_MemWr == MEMWR_SH)
                      && a_lo[0]);
`else
        misaligned = 1'b0;
`endif
        issue       = mem_op && !misaligned;
        align_abort = mem_op && misaligned;
    end

    // Store lanes: data replicated so the byte enables alone pick the target lane
    always_comb begin
        case (Mem_MemWr)
            MEMWR_SH: begin
                be    = a_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{Mem_din[15:0]}};
            end
            MEMWR_SB: begin
                be    = 4'b0001 << a_lo;
                wdata = {4{Mem_din[7:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = Mem_din;
            end
        endcase
        nonmem_data = (Mem_MemtoReg == M2R_LINK) ? {Mem_pc + 30'd2, 2'b00} : Mem_aluout;
    end

    load_align u_load_align (
        .rdata   (dm_rdata),
        .addr_lo (a_lo),
        .opcode  (opcode),
        .value   (load_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        case (state)
            ST_IDLE: begin
                if (issue) begin
                    mem_stall = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_stall = 1'b1;
                if (dm_ack || cnt == CNT_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_be    <= 4'd0;
            dm_addr  <= 30'd0;
            dm_wdata <= 32'd0;
            Wb_data  <= 32'd0;
            Wb_Rw    <= 5'd0;
            Wb_RegWr <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (issue) begin
                        dm_req   <= 1'b1;
                        dm_we    <= is_store;
                        dm_be    <= is_store ? be : 4'b1111;
                        dm_addr  <= Mem_aluout[31:2];
                        dm_wdata <= wdata;
                        Wb_RegWr <= 1'b0;
                    end else begin
                        Wb_data  <= nonmem_data;
                        Wb_Rw    <= Mem_Rw;
                        Wb_RegWr <= Mem_RegWr && !Mem_overflow && !align_abort;
                        bus_err  <= align_abort;
                    end
                end
                ST_WAIT: begin
                    // An ack in the final counted cycle still completes normally
                    if (dm_ack) begin
                        dm_req   <= 1'b0;
                        cnt      <= '0;
                        Wb_data  <= load_val;
                        Wb_Rw    <= Mem_Rw;
                        Wb_RegWr <= is_load && Mem_RegWr;
                    end else if (cnt == CNT_LAST) begin
                        dm_req   <= 1'b0;
                        cnt      <= '0;
                        bus_err  <= 1'b1;
                        Wb_RegWr <= 1'b0;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        Wb_RegWr <= 1'b0;
                    end
                end
                default: Wb_RegWr <= 1'b0;
            endcase
        end
    end

endmodule
